// File: rtl/uart_tx_buf.sv
// Transmit byte FIFO and launcher feeding uart_send; paces launches on uart_tx_busy.
// Define UART_TX_BUF_STAT_EN to build the tx_count completed-byte counter (tied to 0 otherwise).
module uart_tx_buf #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2,
    parameter int BUSY_WAIT  = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          fifo_full,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          uart_en,
    output logic [7:0]    uart_din,
    input  logic          uart_tx_busy,
    output logic          tx_timeout,
    output logic          idle,
    output logic [15:0]   tx_count
);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(BUSY_WAIT + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_next;
    logic [WW-1:0] wait_cnt;
    logic [GW-1:0] gap_cnt;
    logic          do_wr, pop, timeout;

    // Full is judged on the pre-pop level, so a write into a full FIFO drops even if a pop happens.
    assign do_wr      = wr_en && !fifo_full;
    assign level_next = fifo_level + LW'(do_wr) - LW'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (fifo_level != '0 && !uart_tx_busy) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (uart_tx_busy)             state_next = WAIT_DONE;
                else if (wait_cnt == WW'(1))  state_next = GAP;
            end
            WAIT_DONE: if (!uart_tx_busy) state_next = GAP;
            GAP:       if (gap_cnt <= GW'(1)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE:      pop     = (state_next == LAUNCH);
            WAIT_BUSY: timeout = (state_next == GAP);
            default:   ;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_level <= level_next;
            fifo_full  <= (level_next == LW'(DEPTH));
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && fifo_full) overflow <= 1'b1;
            else if (ovf_clr)       overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            uart_en    <= 1'b0;
            uart_din   <= 8'h00;
            tx_timeout <= 1'b0;
            idle       <= 1'b1;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            uart_en    <= pop;
            tx_timeout <= timeout;
            idle       <= (state_next == IDLE) && (level_next == '0);
            if (pop) uart_din <= mem[rd_ptr];
            if (state == LAUNCH)         wait_cnt <= WW'(BUSY_WAIT);
            else if (state == WAIT_BUSY) wait_cnt <= wait_cnt - WW'(1);
            // GAP lasts max(GAP_CYCLES, 1) clocks.
            if (state_next == GAP && state != GAP)  gap_cnt <= GW'(GAP_CYCLES);
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        end
    end

`ifdef UART_TX_BUF_STAT_EN
    logic done;
    assign done = (state == WAIT_DONE) && !uart_tx_busy;

    always_ff @(posedge clk) begin
        if (sys_rst)   tx_count <= '0;
        else if (done) tx_count <= tx_count + 16'd1;
    end
`else
    assign tx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: a queue-based reference model plus a behavioural
// uart_send busy responder, directed scenarios followed by a randomized traffic phase.
module tb_uart_tx_buf;
    localparam int DEPTH      = 16;
    localparam int GAP_CYCLES = 2;
    localparam int BUSY_WAIT  = 16;
    localparam int GAP_LEN    = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
`ifdef UART_TX_BUF_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        sys_rst, wr_en, ovf_clr;
    logic [7:0]  wr_data;
    logic        fifo_full, overflow, uart_en, tx_timeout, idle;
    logic [4:0]  fifo_level;
    logic [7:0]  uart_din;
    logic [15:0] tx_count;
    logic        uart_tx_busy;
    logic        model_busy = 1'b0;
    logic        force_busy = 1'b0;

    assign uart_tx_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    uart_tx_buf #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk(clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data),
        .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr),
        .uart_en(uart_en), .uart_din(uart_din), .uart_tx_busy(uart_tx_busy),
        .tx_timeout(tx_timeout), .idle(idle), .tx_count(tx_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural uart_send: busy rises some clocks after uart_en and stays up for a while.
    bit resp_en   = 1'b1;
    bit rand_mode = 1'b0;
    int rise_dly  = 2;
    int hold_len  = 100;

    initial begin
        int  r, h;
        bit  drop;
        forever begin
            @(negedge clk);
            if (uart_en && resp_en) begin
                r    = rand_mode ? int'($urandom_range(4, 2)) : rise_dly;
                h    = rand_mode ? int'($urandom_range(20, 1)) : hold_len;
                drop = rand_mode && ($urandom_range(7, 0) == 0);
                if (!drop) begin
                    repeat (r - 1) @(negedge clk);
                    model_busy = 1'b1;
                    repeat (h) @(negedge clk);
                    model_busy = 1'b0;
                end
            end
        end
    end

    // Reference model: accepted bytes in order, sticky overflow, completed-byte count.
    logic [7:0] exp_q[$];
    bit         ovf_m, inflight, saw_busy, gap_armed, started, acc;
    bit         prev_en, prev_busy, prev_to, prev_idle;
    logic [7:0] prev_din, last_sent;
    int         k = 0, launch_cyc = 0, fall_cyc = 0, idle_rise_cyc = 0;
    int         n_launch = 0, n_timeout = 0, exp_count = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            k++;
            if (sys_rst) begin
                exp_q.delete();
                ovf_m     = 1'b0;
                exp_count = 0;
                inflight  = 1'b0;
                gap_armed = 1'b0;
                started   = 1'b1;
                check("rst_en", uart_en, 0);
                check("rst_timeout", tx_timeout, 0);
                check("rst_level", fifo_level, 0);
                check("rst_din", uart_din, 0);
            end else if (started) begin
                acc = wr_en && (exp_q.size() < DEPTH);
                if (wr_en && exp_q.size() == DEPTH) ovf_m = 1'b1;
                else if (ovf_clr)                   ovf_m = 1'b0;
                if (uart_en) begin
                    check("en_width", prev_en, 0);
                    check("launch_busy", uart_tx_busy, 0);
                    check("launch_q_nonempty", exp_q.size() > 0, 1);
                    if (gap_armed) check("gap_min", (k - fall_cyc) >= GAP_CYCLES + 1, 1);
                    if (exp_q.size() > 0) check("launch_data", uart_din, exp_q.pop_front());
                    n_launch++;
                    launch_cyc = k;
                    inflight   = 1'b1;
                    saw_busy   = 1'b0;
                    gap_armed  = 1'b0;
                    last_sent  = uart_din;
                end else begin
                    check("din_stable", uart_din, prev_din);
                end
                if (inflight && uart_tx_busy) saw_busy = 1'b1;
                if (inflight && saw_busy && prev_busy && !uart_tx_busy) begin
                    exp_count++;
                    inflight  = 1'b0;
                    fall_cyc  = k;
                    gap_armed = 1'b1;
                end
                if (tx_timeout) begin
                    check("to_width", prev_to, 0);
                    check("to_delay", k - launch_cyc, BUSY_WAIT + 1);
                    check("to_no_busy", saw_busy, 0);
                    inflight  = 1'b0;
                    fall_cyc  = k;
                    gap_armed = 1'b1;
                    n_timeout++;
                end
                if (acc) exp_q.push_back(wr_data);
                check("level", fifo_level, exp_q.size());
                check("full", fifo_full, exp_q.size() == DEPTH);
                check("overflow", overflow, ovf_m);
                check("tx_count", tx_count, STAT ? exp_count : 0);
                if (exp_q.size() != 0) check("idle_with_data", idle, 0);
            end
            if (idle && !prev_idle) idle_rise_cyc = k;
            prev_en   = uart_en;
            prev_din  = uart_din;
            prev_busy = uart_tx_busy;
            prev_to   = tx_timeout;
            prev_idle = idle;
        end
    end

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(idle && exp_q.size() == 0 && !inflight && !uart_tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_in_time", n < budget, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, t0, n;
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        check("reset_level", fifo_level, 0);
        check("reset_full", fifo_full, 0);
        check("reset_overflow", overflow, 0);
        check("reset_en", uart_en, 0);
        check("reset_din", uart_din, 8'h00);
        check("reset_timeout", tx_timeout, 0);
        check("reset_idle", idle, 1);
        check("reset_count", tx_count, 0);

        // Single byte: first-launch latency and idle after busy fall plus gap.
        write_byte(8'hAA);
        check("lat_not_yet", uart_en, 0);
        check("lat_level", fifo_level, 1);
        @(negedge clk);
        check("lat_en", uart_en, 1);
        check("lat_din", uart_din, 8'hAA);
        @(negedge clk);
        check("en_one_cycle", uart_en, 0);
        wait_idle(400);
        check("single_launches", n_launch, 1);
        check("single_idle_gap", idle_rise_cyc - fall_cyc, GAP_LEN);
        check("single_count", tx_count, STAT ? 1 : 0);

        // Burst of 16 while busy is held, then release.
        hold_len   = 20;
        force_busy = 1'b1;
        for (int i = 1; i <= 16; i++) write_byte(8'(i));
        check("burst_full", fifo_full, 1);
        check("burst_level", fifo_level, 16);
        force_busy = 1'b0;
        c0 = n_launch;
        wait_idle(2000);
        check("burst_launches", n_launch - c0, 16);
        check("burst_last", last_sent, 8'h10);
        check("burst_ovf", overflow, 0);
        check("burst_count", tx_count, STAT ? 17 : 0);

        // Overflow: 17th write dropped, clear, set-wins-over-clear.
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
        write_byte(8'h55);
        check("ovf_set", overflow, 1);
        check("ovf_level", fifo_level, 16);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        ovf_clr = 1'b1;
        write_byte(8'h55);
        ovf_clr = 1'b0;
        check("ovf_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr2", overflow, 0);
        force_busy = 1'b0;
        c0 = n_launch;
        wait_idle(2000);
        check("ovf_launches", n_launch - c0, 16);
        check("ovf_last", last_sent, 8'h8F);

        // Timeout: busy never rises; next byte still goes out normally.
        resp_en = 1'b0;
        t0 = n_timeout;
        write_byte(8'h3C);
        wait_idle(200);
        check("to_seen", n_timeout - t0, 1);
        resp_en = 1'b1;
        write_byte(8'h42);
        wait_idle(400);
        check("after_to_sent", last_sent, 8'h42);
        check("after_to_count", tx_count, STAT ? 34 : 0);

        // Write on the same edge as a pop keeps the level at 1.
        force_busy = 1'b1;
        write_byte(8'h5A);
        check("sim_level_before", fifo_level, 1);
        force_busy = 1'b0;
        write_byte(8'h77);
        check("sim_en", uart_en, 1);
        check("sim_din", uart_din, 8'h5A);
        check("sim_level", fifo_level, 1);
        wait_idle(400);
        check("sim_next", last_sent, 8'h77);

        // Reset in WAIT_DONE with 5 queued; no launch while uart_send is still busy.
        hold_len = 60;
        for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i));
        n = 0;
        while (!(fifo_level == 5 && uart_tx_busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mr_reached", n < 20, 1);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        check("mr_level", fifo_level, 0);
        check("mr_en", uart_en, 0);
        check("mr_idle", idle, 1);
        c0 = n_launch;
        repeat (4) @(negedge clk);
        check("mr_no_launch_empty", n_launch - c0, 0);
        write_byte(8'h99);
        repeat (5) @(negedge clk);
        check("mr_held_while_busy", fifo_level, 1);
        check("mr_no_launch_busy", n_launch - c0, 0);
        wait_idle(400);
        check("mr_sent", last_sent, 8'h99);
        check("mr_count", tx_count, STAT ? 1 : 0);

        // Randomized traffic with random busy timing and occasional lost bytes.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(9, 0) < 3);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(31, 0) == 0);
            @(negedge clk);
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        wait_idle(3000);
        rand_mode = 1'b0;
        check("rand_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- Transmit-side byte buffer and launcher, directly upstream of uart_send.
- Accepts bytes from user logic through a write-strobe FIFO interface.
- Presents each byte on uart_din and pulses uart_en to start it. Watches uart_tx_busy to pace bytes back-to-back.
- Lets producers burst bytes without polling the serializer's busy flag.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256. AW = log2(DEPTH).
- GAP_CYCLES, 2: minimum idle clocks after uart_tx_busy falls before the next launch; 0 allowed.
- BUSY_WAIT, 16: max clocks after the uart_en pulse to wait for uart_tx_busy to rise before declaring a timeout; >= 1.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- sys_rst, input, 1: synchronous, active-high reset.
- wr_en, input, 1: write strobe; wr_data is captured when wr_en=1 and fifo_full=0.
- wr_data, input, 8: byte to queue.
- fifo_full, output, 1: fifo_level == DEPTH.
- fifo_level, output, AW+1: number of queued bytes, excluding the byte in flight.
- overflow, output, 1: sticky; set when a write is attempted while full.
- ovf_clr, input, 1: clears overflow.
- uart_en, output, 1: one-cycle start pulse to uart_send.
- uart_din, output, 8: byte for uart_send; held stable from launch until the byte completes.
- uart_tx_busy, input, 1: busy flag from uart_send.
- tx_timeout, output, 1: one-cycle pulse when busy never rose.
- idle, output, 1: high when the FSM is in IDLE and the FIFO is empty.
- tx_count, output, 16: bytes completed (see Optional Feature).

Behaviour:
- Reset values (sys_rst=1 at an edge):
  - pointers=0, fifo_level=0, fifo_full=0, overflow=0
  - uart_en=0, uart_din=8'h00, tx_timeout=0, idle=1, tx_count=0, FSM=IDLE
  - FIFO memory contents are not reset.
- Reset mid-byte: the FSM returns to IDLE and queued bytes are discarded. uart_send is not aborted; the next launch still waits in IDLE until uart_tx_busy=0.
- All outputs are registered.
- FIFO:
  - Circular buffer with AW-bit read/write pointers; both wrap DEPTH-1 -> 0.
  - A write and a pop in the same cycle leave fifo_level unchanged.
  - Write while full: data dropped, level unchanged, overflow<=1.
  - The full decision uses the pre-pop level, so a write to a full FIFO is dropped even if a pop occurs that cycle.
  - If ovf_clr and an overflowing write occur in the same cycle, overflow ends at 1 (set wins).
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE: if fifo_level != 0 and uart_tx_busy == 0, then uart_din <= head byte, pop, uart_en <= 1, -> LAUNCH.
  - LAUNCH: uart_en <= 0, load wait counter = BUSY_WAIT, -> WAIT_BUSY.
  - WAIT_BUSY:
    - If uart_tx_busy == 1 -> WAIT_DONE.
    - Else decrement the counter. When it reaches 0: tx_timeout pulses 1 cycle, the byte is considered lost (not counted), -> GAP.
  - WAIT_DONE: when uart_tx_busy == 0, tx_count += 1 (wraps 16'hFFFF -> 0), -> GAP.
  - GAP: count GAP_CYCLES clocks, then -> IDLE. With GAP_CYCLES=0, GAP lasts exactly 1 clock.
- Latency: wr_en sampled at edge N into an empty FIFO with the FSM in IDLE and busy=0 gives uart_en=1 after edge N+1, for exactly 1 cycle.
- uart_din changes only on IDLE -> LAUNCH.
- uart_en is never high for two consecutive cycles.

Optional Feature:
- Macro: UART_TX_BUF_STAT_EN.
- Defined: tx_count is implemented as above.
- Undefined: the tx_count port remains, tied to 16'h0000; no counter logic is generated. All other behaviour is identical.

Test Plan:
- Single byte: reset, write 8'hAA. Model busy rising 2 clocks after uart_en and staying high 100 clocks. Expect: uart_en pulses once, 1 cycle wide, with uart_din=8'hAA; idle returns after busy falls plus GAP; tx_count=1.
- Burst: write 8'h01..8'h10 on consecutive cycles (DEPTH=16). Expect: fifo_full after the 16th write, 16 launches in order 01..10, at least GAP_CYCLES+1 clocks between each busy fall and the next uart_en, overflow=0, tx_count=16.
- Overflow: fill to 16 with busy held high, write 8'h55. Expect: overflow=1, level=16, 8'h55 never transmitted. ovf_clr -> overflow=0.
- Timeout: write 8'h3C with busy tied 0. Expect: tx_timeout pulse exactly BUSY_WAIT+1 clocks after the uart_en pulse; tx_count unchanged; next byte launches normally.
- Simultaneous write/pop: FIFO holds 1 byte, write 8'h77 on the IDLE->LAUNCH edge. Expect: fifo_level stays 1 and 8'h77 is sent next.
- Mid-operation reset: assert sys_rst during WAIT_DONE with 5 bytes queued. Expect: level=0, uart_en=0, idle=1, and no launch until uart_tx_busy=0 and a new write arrives.
